// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, MIPS encodings and the issue-entry payload.
package alu_pkg;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'b0000,
    ALU_SRL  = 4'b0010,
    ALU_SRA  = 4'b0011,
    ALU_SLT  = 4'b0110,
    ALU_AND  = 4'b1000,
    ALU_OR   = 4'b1001,
    ALU_XOR  = 4'b1010,
    ALU_NOR  = 4'b1011,
    ALU_ADD  = 4'b1100,
    ALU_SUB  = 4'b1110,
    ALU_PASS = 4'b1111
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;

  typedef struct packed {
    alu_op_t           op;
    logic [XLEN-1:0]   v1;
    logic [XLEN-1:0]   v2;
    logic [4:0]        dst;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              illegal;
  } issue_entry_t;

  // Register-register arithmetic/logic functs the ALU can execute directly.
  function automatic logic isArithFunct(input logic [5:0] funct);
    case (funct)
      F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT: isArithFunct = 1'b1;
      default: isArithFunct = 1'b0;
    endcase
  endfunction

  // Shift functs; 000001 and 000101 have no meaning and stay illegal.
  function automatic logic isShiftFunct(input logic [5:0] funct);
    case (funct)
      F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: isShiftFunct = 1'b1;
      default: isShiftFunct = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational translation of a MIPS instruction plus register values into an issue entry.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0]   instr,
  input  logic [31:0]   rs_val,
  input  logic [31:0]   rt_val,
  output issue_entry_t  entry
);

  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [4:0]      shamt;
  logic [4:0]      rtIdx;
  logic [4:0]      rdIdx;
  logic [15:0]     imm;
  logic [XLEN-1:0] signExtImm;
  logic [XLEN-1:0] zeroExtImm;
  logic            unusedRsField;

  assign opcode        = instr[31:26];
  assign rtIdx         = instr[20:16];
  assign rdIdx         = instr[15:11];
  assign shamt         = instr[10:6];
  assign funct         = instr[5:0];
  assign imm           = instr[15:0];
  assign signExtImm    = {{(XLEN-16){imm[15]}}, imm};
  assign zeroExtImm    = {{(XLEN-16){1'b0}}, imm};
  assign unusedRsField = ^instr[25:21];

  logic       legal;
  logic [3:0] opBits;

  // Build the entry per instruction class; anything unrecognised collapses to a bare illegal marker.
  always_comb begin
    entry  = '0;
    legal  = 1'b0;
    opBits = 4'b0000;
    case (opcode)
      OP_RTYPE: begin
        if (isArithFunct(funct)) begin
          opBits = funct[3:0] ^ 4'b1100;
          if (funct == F_ADDU || funct == F_SUBU) opBits[0] = 1'b0;
          entry.op        = alu_op_t'(opBits);
          entry.v1        = rs_val;
          entry.v2        = rt_val;
          entry.dst       = rdIdx;
          entry.reg_write = 1'b1;
          legal           = 1'b1;
        end else if (isShiftFunct(funct)) begin
          entry.op        = alu_op_t'({2'b00, funct[1:0]});
          entry.v1        = funct[2] ? {{(XLEN-5){1'b0}}, rs_val[4:0]} : {{(XLEN-5){1'b0}}, shamt};
          entry.v2        = rt_val;
          entry.dst       = rdIdx;
          entry.reg_write = 1'b1;
          legal           = 1'b1;
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
        entry.v1        = rs_val;
        entry.dst       = rtIdx;
        entry.reg_write = 1'b1;
        legal           = 1'b1;
        case (opcode)
          OP_SLTI: begin entry.op = ALU_SLT;  entry.v2 = signExtImm; end
          OP_ANDI: begin entry.op = ALU_AND;  entry.v2 = zeroExtImm; end
          OP_ORI:  begin entry.op = ALU_OR;   entry.v2 = zeroExtImm; end
          OP_XORI: begin entry.op = ALU_XOR;  entry.v2 = zeroExtImm; end
          OP_LUI:  begin entry.op = ALU_PASS; entry.v2 = {imm, 16'h0000}; end
          default: begin entry.op = ALU_ADD;  entry.v2 = signExtImm; end
        endcase
        if (opcode == OP_LW) entry.mem_read = 1'b1;
      end
      OP_SW: begin
        entry.op        = ALU_ADD;
        entry.v1        = rs_val;
        entry.v2        = signExtImm;
        entry.dst       = rtIdx;
        entry.mem_write = 1'b1;
        legal           = 1'b1;
      end
      default: ;
    endcase
    if (!legal) begin
      entry         = '0;
      entry.illegal = 1'b1;
    end
    if (entry.dst == 5'd0) entry.reg_write = 1'b0;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: decodes instructions and queues them in a 2-entry buffer ahead of the ALU.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_v1,
  output logic [31:0] alu_v2,
  output logic [4:0]  dst,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        illegal
);

  localparam logic [1:0] FullCount = 2'(DEPTH);

  issue_entry_t decoded;
  issue_entry_t mem_q [DEPTH];
  issue_entry_t shownEntry;

  logic [1:0] count_q, count_d;
  logic       wrPtr_q, wrPtr_d;
  logic       rdPtr_q, rdPtr_d;
  logic       inReady_q, inReady_d;
  logic       push;
  logic       pop;

  alu_op_decode uDecode (
    .instr  (instr),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .entry  (decoded)
  );

  assign out_valid = (count_q != 2'd0);
  assign in_ready  = inReady_q;
  assign push      = in_valid && inReady_q && !flush;
  assign pop       = out_valid && out_ready;

  // Pointer/occupancy bookkeeping; flush empties the buffer and wins over any push.
  always_comb begin
    count_d = count_q;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (flush) begin
      count_d = 2'd0;
      wrPtr_d = 1'b0;
      rdPtr_d = 1'b0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + 1'b1;
      if (pop)  rdPtr_d = rdPtr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
    inReady_d = (count_d < FullCount);
  end

  // State and storage registers; the head slot is only rewritten after it has been popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= 2'd0;
      wrPtr_q   <= 1'b0;
      rdPtr_q   <= 1'b0;
      inReady_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q   <= count_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      inReady_q <= inReady_d;
      if (push) mem_q[wrPtr_q] <= decoded;
    end
  end

  // Present the head entry, and all-zero payload whenever nothing is valid.
  always_comb begin
    shownEntry = '0;
    if (out_valid) shownEntry = mem_q[rdPtr_q];
  end

  assign alu_op    = shownEntry.op;
  assign alu_v1    = shownEntry.v1;
  assign alu_v2    = shownEntry.v2;
  assign dst       = shownEntry.dst;
  assign reg_write = shownEntry.reg_write;
  assign mem_read  = shownEntry.mem_read;
  assign mem_write = shownEntry.mem_write;
  assign illegal   = shownEntry.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode results, buffering, back-pressure, flush and reset.
module tb_alu_issue_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [31:0] alu_v1;
  logic [31:0] alu_v2;
  logic [4:0]  dst;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        illegal;

  int    compareCount;
  int    mismatchCount;
  string stepName;

  alu_issue_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .alu_v1    (alu_v1),
    .alu_v2    (alu_v2),
    .dst       (dst),
    .reg_write (reg_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .illegal   (illegal)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      mismatchCount++;
      $error("[TB] FAIL %s/%s: observed=0x%0h expected=0x%0h", stepName, tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input logic expValid, input logic [3:0] expOp,
                             input logic [31:0] expV1, input logic [31:0] expV2,
                             input logic [4:0] expDst, input logic expRw,
                             input logic expMr, input logic expMw, input logic expIll);
    checkField("out_valid", {31'b0, out_valid}, {31'b0, expValid});
    checkField("alu_op",    {28'b0, alu_op},    {28'b0, expOp});
    checkField("alu_v1",    alu_v1,             expV1);
    checkField("alu_v2",    alu_v2,             expV2);
    checkField("dst",       {27'b0, dst},       {27'b0, expDst});
    checkField("reg_write", {31'b0, reg_write}, {31'b0, expRw});
    checkField("mem_read",  {31'b0, mem_read},  {31'b0, expMr});
    checkField("mem_write", {31'b0, mem_write}, {31'b0, expMw});
    checkField("illegal",   {31'b0, illegal},   {31'b0, expIll});
  endtask

  task automatic checkReady(input logic exp);
    checkField("in_ready", {31'b0, in_ready}, {31'b0, exp});
  endtask

  task automatic applyStimulus(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    in_valid = 1'b1;
    instr    = i;
    rs_val   = rs;
    rt_val   = rt;
  endtask

  // Offer one instruction for exactly one cycle into an empty buffer.
  task automatic issueOne(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    applyStimulus(i, rs, rt);
    tick();
    in_valid = 1'b0;
  endtask

  // Single linear directed sequence.
  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    instr     = 32'h0;
    rs_val    = 32'h0;
    rt_val    = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    tick();
    stepName = "reset";
    checkOutput(1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkReady(1'b1);
    reset = 1'b0;

    stepName = "add";
    issueOne(32'h00221820, 32'd5, 32'd7);
    checkOutput(1'b1, 4'b1100, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    stepName = "add_popped";
    checkField("out_valid", {31'b0, out_valid}, 32'd0);

    stepName = "sll";
    issueOne(32'h00011100, 32'h25, 32'h1);
    checkOutput(1'b1, 4'b0000, 32'd4, 32'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    stepName = "sllv";
    issueOne(32'h00611004, 32'h25, 32'h1);
    checkOutput(1'b1, 4'b0000, 32'd5, 32'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    stepName = "srav";
    issueOne(32'h00625007, 32'h123, 32'h80000000);
    checkOutput(1'b1, 4'b0011, 32'd3, 32'h80000000, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    stepName = "subu";
    issueOne(32'h00224023, 32'd9, 32'd4);
    checkOutput(1'b1, 4'b1110, 32'd9, 32'd4, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    stepName = "lui";
    issueOne(32'h3C041234, 32'h99, 32'h0);
    checkOutput(1'b1, 4'b1111, 32'h99, 32'h12340000, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    stepName = "slti";
    issueOne(32'h2825FFFF, 32'd11, 32'h0);
    checkOutput(1'b1, 4'b0110, 32'd11, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    stepName = "ori";
    issueOne(32'h34298000, 32'h1, 32'h0);
    checkOutput(1'b1, 4'b1001, 32'h1, 32'h00008000, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    stepName = "lw";
    issueOne(32'h8C260008, 32'h100, 32'h0);
    checkOutput(1'b1, 4'b1100, 32'h100, 32'h8, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();

    stepName = "sw";
    issueOne(32'hAC27FFFC, 32'h100, 32'h55);
    checkOutput(1'b1, 4'b1100, 32'h100, 32'hFFFFFFFC, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    stepName = "illegal_op";
    issueOne(32'h7C000000, 32'd5, 32'd7);
    checkOutput(1'b1, 4'b0000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    stepName = "illegal_funct";
    issueOne(32'h00000001, 32'd5, 32'd7);
    checkOutput(1'b1, 4'b0000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    stepName = "add_r0";
    issueOne(32'h00220020, 32'd5, 32'd7);
    checkOutput(1'b1, 4'b1100, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Back-pressure: A and B fill the buffer, C waits upstream, then all drain in order.
    stepName = "bp";
    out_ready = 1'b0;
    applyStimulus(32'h20010001, 32'd100, 32'd0);
    checkReady(1'b1);
    tick();
    checkReady(1'b1);
    applyStimulus(32'h20010002, 32'd100, 32'd0);
    tick();
    stepName = "bp_full";
    checkReady(1'b0);
    applyStimulus(32'h20010003, 32'd100, 32'd0);
    checkOutput(1'b1, 4'b1100, 32'd100, 32'd1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    stepName = "bp_hold";
    checkReady(1'b0);
    checkOutput(1'b1, 4'b1100, 32'd100, 32'd1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    stepName = "bp_headB";
    checkReady(1'b1);
    checkField("alu_v2", alu_v2, 32'd2);
    tick();
    in_valid = 1'b0;
    stepName = "bp_headC";
    checkField("out_valid", {31'b0, out_valid}, 32'd1);
    checkField("alu_v2", alu_v2, 32'd3);
    tick();
    stepName = "bp_drained";
    checkField("out_valid", {31'b0, out_valid}, 32'd0);

    // Flush with a full buffer while another instruction is offered.
    stepName = "flush_full";
    out_ready = 1'b0;
    applyStimulus(32'h20010004, 32'd100, 32'd0);
    tick();
    applyStimulus(32'h20010005, 32'd100, 32'd0);
    tick();
    applyStimulus(32'h20010006, 32'd100, 32'd0);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput(1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkReady(1'b1);
    out_ready = 1'b1;
    tick();
    checkField("out_valid_after", {31'b0, out_valid}, 32'd0);

    // Flush with one entry while in_ready is high: the flush-cycle instruction must be dropped.
    stepName = "flush_drop";
    out_ready = 1'b0;
    applyStimulus(32'h20010007, 32'd100, 32'd0);
    tick();
    applyStimulus(32'h20010008, 32'd100, 32'd0);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checkField("out_valid", {31'b0, out_valid}, 32'd0);
    checkReady(1'b1);
    out_ready = 1'b1;
    tick();
    checkField("out_valid_after", {31'b0, out_valid}, 32'd0);

    // Reset in the middle of a stream returns to the empty, all-zero state.
    stepName = "reset_mid";
    out_ready = 1'b0;
    applyStimulus(32'h20010009, 32'd100, 32'd0);
    tick();
    applyStimulus(32'h2001000A, 32'd100, 32'd0);
    tick();
    applyStimulus(32'h2001000B, 32'd100, 32'd0);
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    checkOutput(1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkReady(1'b1);
    out_ready = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage sitting directly upstream of the pipeline ALU; the producer side of the ALU's {op, v1, v2} interface.
- Takes a fetched MIPS instruction plus register-file read values, translates it into the 4-bit ALU op code and operand pair, and registers the result.
- Holds results in a 2-entry issue buffer with valid/ready handshakes on both sides, so EX back-pressure never drops or reorders instructions.
- Also emits destination register and write/memory control to EX.

Parameters:
- DEPTH, 2, issue-buffer entries; fixed at 2, ready logic relies on it.
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction and operands valid this cycle.
- in_ready  out  1  buffer can accept; registered.
- instr  in  32  MIPS instruction word.
- rs_val  in  32  value of register rs.
- rt_val  in  32  value of register rt.
- flush  in  1  discard all buffered entries; has priority over push.
- out_valid  out  1  head entry valid.
- out_ready  in  1  EX accepts head entry.
- alu_op  out  4  ALU op code.
- alu_v1  out  32  ALU operand 1.
- alu_v2  out  32  ALU operand 2.
- dst  out  5  destination register number.
- reg_write  out  1  result is written back.
- mem_read  out  1  load.
- mem_write  out  1  store.
- illegal  out  1  unsupported instruction; op=0, reg_write=0.

Behaviour:
- Reset (sync, high): count=0, rd/wr pointers=0, out_valid=0, in_ready=1, and all payload outputs 0.
- Push when in_valid && in_ready && !flush. Pop when out_valid && out_ready.
- Latency: an instruction pushed into an empty buffer appears on the outputs the next cycle.
- in_ready is registered and equals (count_next < 2).
- Push and pop in the same cycle: count unchanged. When full, in_ready=0, so no push can occur.
- flush: next cycle count=0, out_valid=0, in_ready=1. An in_valid asserted in the flush cycle is dropped.
- Outputs are driven from the head entry (FIFO order). Outputs are held stable while out_valid && !out_ready.
- Op codes:
  - SLL 0000, SRL 0010, SRA 0011, SLT 0110.
  - AND 1000, OR 1001, XOR 1010, NOR 1011.
  - ADD 1100, SUB 1110, PASS 1111 (PASS outputs v2).
- R-type (opcode 0), funct[5]=1: alu_op = funct[3:0] ^ 4'b1100.
  - addu (100001) forces bit0 to 0, giving ADD.
  - subu (100011) forces bit0 to 0, giving SUB.
  - v1=rs_val, v2=rt_val, dst=rd.
  - Supported: add, addu, sub, subu, and, or, xor, nor, slt.
- R-type, funct[5]=0 (shifts):
  - alu_op = {2'b00, funct[1:0]}.
  - v1 = funct[2] ? rs_val[4:0] zero-extended : shamt zero-extended.
  - v2=rt_val, dst=rd.
  - Supported: sll, srl, sra, sllv, srlv, srav. funct 000001 and 000101 are illegal.
- I-type, all with v1=rs_val, dst=rt:
  - addi/addiu → ADD, sign-extended imm.
  - slti → SLT, sign-extended imm.
  - andi/ori/xori → AND/OR/XOR, zero-extended imm.
  - lui → PASS, v2 = {imm, 16'h0}.
- lw → ADD, sign-extended imm, mem_read=1, reg_write=1, dst=rt.
- sw → ADD, sign-extended imm, mem_write=1, reg_write=0.
- Writes to register 0 (dst=0) force reg_write=0.
- Any other encoding: illegal=1, still pushed in order, no side effects.

Decomposition:
- Shared package alu_pkg:
  - alu_op_t as a 4-bit enum carrying the codes above (also imported by the ALU).
  - Opcode/funct localparams.
  - issue_entry_t struct {op, v1, v2, dst, reg_write, mem_read, mem_write, illegal}.
- Sub-module alu_op_decode: purely combinational, instr/rs_val/rt_val → issue_entry_t. The top level holds the 2-entry buffer and handshake logic.

Test Plan:
- add $3,$1,$2 (0x00221820), rs_val=5, rt_val=7 → next cycle op=1100, v1=5, v2=7, dst=3, reg_write=1.
- sll $2,$1,4 (0x00011100), rt_val=0x1 → op=0000, v1=4, v2=1, dst=2. sllv (funct 000100) with rs_val=0x25 → v1=5.
- lui $4,0x1234 (0x3C041234) → op=1111, v2=0x12340000, dst=4. slti $5,$1,-1 (0x2825FFFF) → op=0110, v2=0xFFFFFFFF.
- Back-pressure: hold out_ready=0 and offer 3 instructions back-to-back.
  - in_ready drops after 2 are accepted; the third is held upstream.
  - Release out_ready → all 3 emerge in order, none lost or duplicated.
- flush with 2 entries buffered while in_valid=1 → next cycle out_valid=0, in_ready=1, and the flush-cycle instruction never appears. Assert reset mid-stream → same empty state, with all outputs 0.
- Illegal opcode 0x7C000000 → out_valid=1, illegal=1, reg_write=0, op=0000. Writing $0 (add $0,$1,$2) → reg_write=0.
